// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset/clock bring-up sequencer.
`timescale 1ns / 1ps

package rst_seq_pkg;

  // Sequencer states, in bring-up order.
  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  // The button is active-low, so it resets to the released level (1).
  // Lock resets to 0 so nothing can run until the PLL really locks.
  localparam logic BtnRstVal  = 1'b1;
  localparam logic LockRstVal = 1'b0;

  // Sizes the shared sequencer counter from its three possible limits.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by an optional debounce filter.
// With Cycles == 1 the output is the plain synchronized level, adding no latency.
// With Cycles > 1 the output only takes a new level once the synchronized input
// has disagreed with it for Cycles consecutive clocks.
`timescale 1ns / 1ps

module sync_debounce #(
  parameter int unsigned Cycles   = 1,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q, sync2_q;

  // Metastability chain for the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ResetVal;
      sync2_q <= ResetVal;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  if (Cycles <= 1) begin : g_plain
    assign q_o = sync2_q;
  end else begin : g_debounce
    localparam int unsigned    CntW    = $clog2(Cycles);
    localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == CntLast) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Debounced level and its qualification counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        level_q <= ResetVal;
        cnt_q   <= '0;
      end else begin
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign q_o = level_q;
  end

endmodule

// File: rtl/rst_seq.sv
// Reset and clock bring-up sequencer.
// Pulses the PLL reset, waits for lock, requires lock to stay up for LockDelay
// cycles, then releases a registered downstream reset. A debounced button press
// restarts the whole sequence from the PLL reset.
// Optional: define RST_SEQ_LOCK_TIMEOUT_EN to retry the PLL reset when lock does
// not arrive within LockTimeout cycles (sticky timeout_o); otherwise timeout_o is 0.
`timescale 1ns / 1ps

module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned PllRstCycles   = 16,
  parameter int unsigned LockDelay      = 1024,
  parameter int unsigned DebounceCycles = 120000,
  parameter int unsigned LockTimeout    = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pll_lock_i,
  input  logic btn_ni,
  output logic pll_resetb_o,
  output logic rst_no,
  output logic ready_o,
  output logic lock_lost_o,
  output logic timeout_o
);

  localparam int unsigned     CntMax     = max3(PllRstCycles, LockDelay, LockTimeout);
  localparam int unsigned     CntW       = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PllLast    = CntW'(PllRstCycles - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(LockDelay - 1);
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LockTimeout - 1);
`endif

  logic lock_sync;
  logic btn_level;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            pll_resetb_q, pll_resetb_d;
  logic            rst_n_q, ready_q, run_d;
  logic            lock_lost_q, lock_lost_d;
  logic            timeout_q, timeout_d;

  sync_debounce #(
    .Cycles  (1),
    .ResetVal(LockRstVal)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pll_lock_i),
    .q_o   (lock_sync)
  );

  sync_debounce #(
    .Cycles  (DebounceCycles),
    .ResetVal(BtnRstVal)
  ) u_btn_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (btn_ni),
    .q_o   (btn_level)
  );

  // Shared counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Next state, counter, sticky flags and registered output decodes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    lock_lost_d = lock_lost_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PllLast) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = S_STABLE;
        end
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          timeout_d = 1'b1;
          state_d   = S_PLL_RST;
        end
`endif
      end
      S_STABLE: begin
        if (!lock_sync) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == StableLast) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_sync) begin
          lock_lost_d = 1'b1;
          state_d     = S_WAIT_LOCK;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // A debounced press overrides everything and pins the counter at 0.
    if (!btn_level) begin
      state_d     = S_PLL_RST;
      cnt_d       = '0;
      lock_lost_d = 1'b0;
      timeout_d   = 1'b0;
    end

    // Outputs are decoded from the next state so they switch with the state flops.
    pll_resetb_d = (state_d != S_PLL_RST);
    run_d        = (state_d == S_RUN);
  end

  // Sequencer state and glitch-free registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      pll_resetb_q <= 1'b0;
      rst_n_q      <= 1'b0;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_resetb_q <= pll_resetb_d;
      rst_n_q      <= run_d;
      ready_q      <= run_d;
      lock_lost_q  <= lock_lost_d;
      timeout_q    <= timeout_d;
    end
  end

  assign pll_resetb_o = pll_resetb_q;
  assign rst_no       = rst_n_q;
  assign ready_o      = ready_q;
  assign lock_lost_o  = lock_lost_q;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq with small parameters.
// The PLL is modelled as locking as soon as its reset is released (and while
// lock_en is high), so lock reaches the sequencer through the 2-flop sync.
// Observed vector order: {pll_resetb_o, rst_no, ready_o, lock_lost_o, timeout_o}.
`timescale 1ns / 1ps

module tb_rst_seq;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni, btn_ni, lock_en, pll_lock_i;
  logic pll_resetb_o, rst_no, ready_o, lock_lost_o, timeout_o;
  logic [4:0] obs;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       btn;
    logic       lock;
    int         n;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[16];

  rst_seq #(
    .PllRstCycles  (4),
    .LockDelay     (8),
    .DebounceCycles(5),
    .LockTimeout   (20)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pll_lock_i  (pll_lock_i),
    .btn_ni      (btn_ni),
    .pll_resetb_o(pll_resetb_o),
    .rst_no      (rst_no),
    .ready_o     (ready_o),
    .lock_lost_o (lock_lost_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  assign pll_lock_i = pll_resetb_o & lock_en;
  assign obs = {pll_resetb_o, rst_no, ready_o, lock_lost_o, timeout_o};

  task automatic chk(input string name, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (pll_resetb,rst_n,ready,lost,timeout) at %0t",
               name, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle just past the edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic b, input logic l, input int n,
                         input logic [4:0] e);
    vecs[i].btn  = b;
    vecs[i].lock = l;
    vecs[i].n    = n;
    vecs[i].exp  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Edge counts are from reset release (E0).
    set_vec(0,  1, 1, 3,  5'b00000);  // E3  still pulsing PLL reset
    set_vec(1,  1, 1, 1,  5'b10000);  // E4  PLL reset released
    set_vec(2,  1, 1, 10, 5'b10000);  // E14 still qualifying lock
    set_vec(3,  1, 1, 1,  5'b11100);  // E15 run: 2 sync + 8 + 1 after E4
    set_vec(4,  1, 0, 1,  5'b11100);  // E16 one-cycle lock drop in flight
    set_vec(5,  1, 1, 1,  5'b11100);  // E17
    set_vec(6,  1, 1, 1,  5'b10010);  // E18 three edges after the drop
    set_vec(7,  1, 1, 8,  5'b10010);  // E26
    set_vec(8,  1, 1, 1,  5'b11110);  // E27 back in run, lost stays set
    set_vec(9,  1, 0, 2,  5'b11110);  // E29 two-cycle drop to reach S_STABLE
    set_vec(10, 1, 1, 1,  5'b10010);  // E30 waiting for lock
    set_vec(11, 1, 1, 6,  5'b10010);  // E36 stable since E32, count 4
    set_vec(12, 1, 0, 1,  5'b10010);  // E37 glitch seen by FSM at count 6
    set_vec(13, 1, 1, 3,  5'b10010);  // E40 would have released without glitch
    set_vec(14, 1, 1, 7,  5'b10010);  // E47
    set_vec(15, 1, 1, 1,  5'b11110);  // E48 released 8 lock cycles after restart

    // Reset state
    rst_ni  = 1'b0;
    btn_ni  = 1'b1;
    lock_en = 1'b1;
    adv(3);
    chk("reset_state", 5'b00000);
    rst_ni = 1'b1;

    // Bring-up, lock loss and stable-glitch sequence
    for (int i = 0; i < 16; i++) begin
      btn_ni  = vecs[i].btn;
      lock_en = vecs[i].lock;
      adv(vecs[i].n);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Button bounce: pulses of 1-3 cycles must be filtered out
    begin
      logic bl[6];
      int   bn[6];
      bl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bn = '{1, 2, 3, 2, 2, 6};
      for (int k = 0; k < 6; k++) begin
        btn_ni = bl[k];
        for (int c = 0; c < bn[k]; c++) begin
          adv(1);
          chk("bounce", 5'b11110);
        end
      end
    end

    // Held press: debounced after 2 sync + 5 cycles, FSM acts one edge later
    btn_ni = 1'b0;
    adv(6);
    chk("press_not_yet", 5'b11110);
    adv(2);
    chk("press_reset", 5'b00000);
    adv(2);
    chk("press_held", 5'b00000);
    btn_ni = 1'b1;
    adv(10);
    chk("release_debounce", 5'b00000);
    adv(1);
    chk("release_pll_up", 5'b10000);
    adv(10);
    chk("release_pre_run", 5'b10000);
    adv(1);
    chk("release_run", 5'b11100);

    // Async reset while in S_STABLE
    lock_en = 1'b0;
    adv(2);
    chk("stable_drop", 5'b11100);
    lock_en = 1'b1;
    adv(1);
    chk("stable_wait", 5'b10010);
    adv(3);
    chk("stable_mid", 5'b10010);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_reset", 5'b00000);
    adv(2);
    chk("async_reset_hold", 5'b00000);
    rst_ni = 1'b1;
    adv(3);
    chk("restart_pll_rst", 5'b00000);
    adv(1);
    chk("restart_pll_up", 5'b10000);
    adv(10);
    chk("restart_pre_run", 5'b10000);
    adv(1);
    chk("restart_run", 5'b11100);

    // Lock never arrives: retries with the timeout feature, waits forever without
    rst_ni  = 1'b0;
    lock_en = 1'b0;
    adv(2);
    rst_ni = 1'b1;
    adv(4);
    chk("nolock_wait", 5'b10000);
    adv(19);
    chk("nolock_e23", 5'b10000);
    adv(1);
    chk("nolock_e24", TmoEn ? 5'b00001 : 5'b10000);
    adv(3);
    chk("nolock_e27", TmoEn ? 5'b00001 : 5'b10000);
    adv(1);
    chk("nolock_e28", TmoEn ? 5'b10001 : 5'b10000);
    adv(19);
    chk("nolock_e47", TmoEn ? 5'b10001 : 5'b10000);
    adv(1);
    chk("nolock_e48", TmoEn ? 5'b00001 : 5'b10000);

    // Debounced press clears the sticky timeout
    btn_ni = 1'b0;
    adv(8);
    chk("press_clears_timeout", 5'b00000);
    btn_ni = 1'b1;
    adv(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
